hps_uart_rx: RTL and testbench

HPS_UART_RX -- requirements
Module: hps_uart_rx

---
 rtl/hps_uart_pkg.sv | 23 ++
 rtl/hps_uart_rx_sync_fifo.sv | 70 +++++++
 rtl/hps_uart_rx.sv | 175 +++++++++++++++++
 tb/tb_hps_uart_rx.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hps_uart_pkg.sv
// Shared definitions for the HPS UART receive path: FSM states and
// oversampling constants used by the receiver and its testbench.
package hps_uart_pkg;

  // Number of divider ticks that make up one serial bit period.
  localparam int OVERSAMPLE = 16;

  // Tick index at which the start bit is re-checked (middle of the bit).
  localparam int MID_SAMPLE = 8;

  // Width of the per-bit tick counter.
  localparam int TICK_W = $clog2(OVERSAMPLE);

  // Receiver frame states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_HIGH
  } rx_state_e;

endpackage

// File: rtl/hps_uart_rx_sync_fifo.sv
// First-word-fallthrough synchronous FIFO. The head entry is presented on
// pop_data whenever the FIFO is non-empty; pop_data reads as zero when empty.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  assign pop_data = empty ? '0 : mem[rd_ptr];

  // Storage array; contents only matter where the count says they are live.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  // Occupancy count; simultaneous push and pop leave it unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/hps_uart_rx.sv
// 8N1 UART receiver for the HPS UART0 TX line. The line is synchronized,
// oversampled 16x, framed by a small FSM and buffered in a FWFT FIFO.
import hps_uart_pkg::*;

module hps_uart_rx #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk_clk,
  input  logic       reset_reset,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       frame_err_o,
  output logic       overrun_o
);

  // Clocks per oversample tick, rounded to nearest and never below one.
  localparam int DIV_RAW = (CLK_HZ + (OVERSAMPLE / 2) * BAUD) / (OVERSAMPLE * BAUD);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;

  logic              rx_meta;
  logic              rx_sync;
  logic              rx_prev;
  logic              start_edge;
  logic [DIV_W-1:0]  div_cnt;
  logic              tick;

  rx_state_e         state;
  rx_state_e         state_next;
  logic [TICK_W-1:0] tick_cnt;
  logic [TICK_W-1:0] tick_next;
  logic [2:0]        bit_cnt;
  logic [2:0]        bit_next;
  logic [7:0]        shift_reg;
  logic [7:0]        shift_next;
  logic              push_req;
  logic              frame_err_next;

  logic              fifo_empty;
  logic              fifo_full;

  assign start_edge = rx_prev && !rx_sync;
  assign tick       = (div_cnt == DIV_W'(DIV - 1));

  // Two-flop synchronizer plus one history flop for falling-edge detection.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // Oversample divider, realigned on every start edge so ticks track the frame.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      div_cnt <= '0;
    end else if ((state == ST_IDLE && start_edge) || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Frame FSM state and datapath registers.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state       <= ST_IDLE;
      tick_cnt    <= '0;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      state       <= state_next;
      tick_cnt    <= tick_next;
      bit_cnt     <= bit_next;
      shift_reg   <= shift_next;
      frame_err_o <= frame_err_next;
      overrun_o   <= push_req && fifo_full && !ready_i;
    end
  end

  // Next-state logic: mid-bit sampling, LSB-first shifting and stop-bit checks.
  always_comb begin
    state_next     = state;
    tick_next      = tick_cnt;
    bit_next       = bit_cnt;
    shift_next     = shift_reg;
    push_req       = 1'b0;
    frame_err_next = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start_edge) begin
          state_next = ST_START;
          tick_next  = '0;
        end
      end

      ST_START: begin
        if (tick) begin
          if (tick_cnt == TICK_W'(MID_SAMPLE - 1)) begin
            tick_next  = '0;
            bit_next   = '0;
            state_next = rx_sync ? ST_IDLE : ST_DATA;
          end else begin
            tick_next = tick_cnt + TICK_W'(1);
          end
        end
      end

      ST_DATA: begin
        if (tick) begin
          tick_next = tick_cnt + TICK_W'(1);
          if (tick_cnt == TICK_W'(OVERSAMPLE - 1)) begin
            shift_next = {rx_sync, shift_reg[7:1]};
            bit_next   = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state_next = ST_STOP;
            end
          end
        end
      end

      ST_STOP: begin
        if (tick) begin
          tick_next = tick_cnt + TICK_W'(1);
          if (tick_cnt == TICK_W'(OVERSAMPLE - 1)) begin
            if (rx_sync) begin
              push_req   = 1'b1;
              state_next = ST_IDLE;
            end else begin
              frame_err_next = 1'b1;
              state_next     = ST_WAIT_HIGH;
            end
          end
        end
      end

      ST_WAIT_HIGH: begin
        if (rx_sync) begin
          state_next = ST_IDLE;
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk_clk),
    .reset     (reset_reset),
    .push      (push_req),
    .push_data (shift_reg),
    .pop       (ready_i),
    .pop_data  (data_o),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign valid_o = !fifo_empty;

endmodule

// File: tb/tb_hps_uart_rx.sv
// Self-checking bench for hps_uart_rx: serial frames are generated bit by bit,
// delivered bytes and error pulses are collected by a monitor, and each test
// compares them to what an 8N1 receiver with a bounded buffer must produce.
module tb_hps_uart_rx;

  localparam int CLK_HZ     = 1843200;
  localparam int BAUD       = 115200;
  localparam int FIFO_DEPTH = 8;
  localparam int BIT_CLKS   = 16;
  localparam int SYNC_LAT   = 2;
  // Start edge to stop-bit middle is 9.5 bits; one more clock to show the byte.
  localparam int EXP_LAT    = SYNC_LAT + BIT_CLKS / 2 + 9 * BIT_CLKS + 1;

  logic       clk_clk     = 1'b0;
  logic       reset_reset = 1'b1;
  logic       rx_i        = 1'b1;
  logic       ready_i     = 1'b1;
  logic [7:0] data_o;
  logic       valid_o;
  logic       frame_err_o;
  logic       overrun_o;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [7:0] rcv_q[$];
  logic [7:0] exp_q[$];
  int         valid_cycles    = 0;
  int         first_valid_cyc = -1;
  int         frame_err_cnt   = 0;
  int         overrun_cnt     = 0;
  logic       prev_pulse      = 1'b0;
  bit         rand_ready      = 1'b0;

  hps_uart_rx #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk_clk     (clk_clk),
    .reset_reset (reset_reset),
    .rx_i        (rx_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o)
  );

  // Free-running clock.
  always #5 clk_clk = ~clk_clk;

  // Cycle counter used for latency measurement.
  always @(posedge clk_clk) cyc <= cyc + 1;

  // Randomly throttle the consumer when enabled.
  always @(posedge clk_clk) begin
    if (rand_ready) begin
      #1;
      ready_i = ($urandom_range(0, 1) == 1);
    end
  end

  // Monitor on the falling edge: collect popped bytes, count pulses, and
  // check that error pulses are single-cycle and never coincide.
  always @(negedge clk_clk) begin
    if (!reset_reset) begin
      if (valid_o && ready_i) rcv_q.push_back(data_o);
      if (valid_o) begin
        valid_cycles++;
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
      end
      if (frame_err_o) frame_err_cnt++;
      if (overrun_o) overrun_cnt++;
      if (frame_err_o || overrun_o) begin
        checks++;
        if ((frame_err_o && overrun_o) || prev_pulse) begin
          errors++;
          $display("[TB] FAIL pulse_rule: frame_err_o=%0b overrun_o=%0b prev_cycle_pulse=%0b, required isolated single pulse",
                   frame_err_o, overrun_o, prev_pulse);
        end
      end
      prev_pulse = frame_err_o || overrun_o;
    end else begin
      prev_pulse = 1'b0;
    end
  end

  // Global guard so the run always ends.
  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion before limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic hold(input logic v, input int n);
    rx_i = v;
    repeat (n) begin
      @(posedge clk_clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    hold(1'b0, BIT_CLKS);
    for (int i = 0; i < 8; i++) hold(b[i], BIT_CLKS);
    hold(stop_bit, BIT_CLKS);
  endtask

  task automatic clear_stats();
    rcv_q.delete();
    exp_q.delete();
    valid_cycles    = 0;
    first_valid_cyc = -1;
    frame_err_cnt   = 0;
    overrun_cnt     = 0;
  endtask

  task automatic test_reset();
    reset_reset = 1'b1;
    hold(1'b1, 4);
    checks++;
    if (valid_o !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_valid: got %b, required 0", valid_o);
    end
    checks++;
    if (data_o !== 8'h00) begin
      errors++; $display("[TB] FAIL reset_data: got %h, required 00", data_o);
    end
    checks++;
    if (frame_err_o !== 1'b0 || overrun_o !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_pulses: got fe=%b ov=%b, required 0 0", frame_err_o, overrun_o);
    end
    reset_reset = 1'b0;
    hold(1'b1, 20);
    checks++;
    if (valid_o !== 1'b0) begin
      errors++; $display("[TB] FAIL idle_valid: got %b, required 0", valid_o);
    end
  endtask

  task automatic test_single_byte();
    int t0;
    clear_stats();
    ready_i = 1'b1;
    t0 = cyc;
    send_frame(8'h55, 1'b1);
    hold(1'b1, 8);
    checks++;
    if (valid_cycles != 1) begin
      errors++; $display("[TB] FAIL single_valid_len: got %0d cycles, required 1", valid_cycles);
    end
    checks++;
    if (rcv_q.size() != 1 || rcv_q[0] !== 8'h55) begin
      errors++; $display("[TB] FAIL single_data: got %0d bytes (first %h), required 1 byte 55",
                         rcv_q.size(), (rcv_q.size() > 0) ? rcv_q[0] : 8'hxx);
    end
    checks++;
    if ((first_valid_cyc - t0) < EXP_LAT - 1 || (first_valid_cyc - t0) > EXP_LAT + 1) begin
      errors++; $display("[TB] FAIL single_latency: got %0d clocks, required %0d+-1", first_valid_cyc - t0, EXP_LAT);
    end
  endtask

  task automatic test_glitch();
    clear_stats();
    ready_i = 1'b1;
    hold(1'b0, 4);
    hold(1'b1, 40);
    checks++;
    if (valid_cycles != 0 || frame_err_cnt != 0) begin
      errors++; $display("[TB] FAIL glitch_reject: got valid_cycles=%0d fe=%0d, required 0 0", valid_cycles, frame_err_cnt);
    end
    send_frame(8'hC7, 1'b1);
    hold(1'b1, 8);
    checks++;
    if (rcv_q.size() != 1 || rcv_q[0] !== 8'hC7) begin
      errors++; $display("[TB] FAIL glitch_recover: got %0d bytes (first %h), required 1 byte c7",
                         rcv_q.size(), (rcv_q.size() > 0) ? rcv_q[0] : 8'hxx);
    end
  endtask

  task automatic test_frame_error();
    clear_stats();
    ready_i = 1'b1;
    send_frame(8'hA3, 1'b0);
    hold(1'b0, 40);
    hold(1'b1, 20);
    send_frame(8'h3C, 1'b1);
    hold(1'b1, 8);
    checks++;
    if (frame_err_cnt != 1) begin
      errors++; $display("[TB] FAIL ferr_count: got %0d, required 1", frame_err_cnt);
    end
    checks++;
    if (overrun_cnt != 0) begin
      errors++; $display("[TB] FAIL ferr_overrun: got %0d, required 0", overrun_cnt);
    end
    checks++;
    if (rcv_q.size() != 1 || rcv_q[0] !== 8'h3C) begin
      errors++; $display("[TB] FAIL ferr_data: got %0d bytes (first %h), required 1 byte 3c",
                         rcv_q.size(), (rcv_q.size() > 0) ? rcv_q[0] : 8'hxx);
    end
  endtask

  task automatic test_overrun();
    int exp_ov;
    clear_stats();
    exp_ov  = 0;
    ready_i = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(8'(i));
      else exp_ov++;
      send_frame(8'(i), 1'b1);
      hold(1'b1, 4);
      if (i == 8) begin
        checks++;
        if (overrun_cnt != 0 || valid_o !== 1'b1) begin
          errors++; $display("[TB] FAIL ovr_at_full: got ov=%0d valid=%b, required 0 1", overrun_cnt, valid_o);
        end
      end
    end
    checks++;
    if (overrun_cnt != exp_ov) begin
      errors++; $display("[TB] FAIL ovr_count: got %0d, required %0d", overrun_cnt, exp_ov);
    end
    ready_i = 1'b1;
    hold(1'b1, 20);
    checks++;
    if (rcv_q.size() != exp_q.size()) begin
      errors++; $display("[TB] FAIL ovr_drain_len: got %0d, required %0d", rcv_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (rcv_q[i] !== exp_q[i]) begin
          errors++; $display("[TB] FAIL ovr_drain[%0d]: got %h, required %h", i, rcv_q[i], exp_q[i]);
        end
      end
    end
    checks++;
    if (valid_o !== 1'b0) begin
      errors++; $display("[TB] FAIL ovr_empty: got valid %b, required 0", valid_o);
    end
  endtask

  task automatic test_reset_mid_frame();
    clear_stats();
    ready_i = 1'b0;
    send_frame(8'h42, 1'b1);
    hold(1'b1, 8);
    hold(1'b0, BIT_CLKS);
    hold(1'b1, 4 * BIT_CLKS + BIT_CLKS / 2);
    reset_reset = 1'b1;
    hold(1'b1, 3);
    reset_reset = 1'b0;
    hold(1'b1, 1);
    checks++;
    if (valid_o !== 1'b0 || data_o !== 8'h00) begin
      errors++; $display("[TB] FAIL rst_mid_empty: got valid=%b data=%h, required 0 00", valid_o, data_o);
    end
    clear_stats();
    ready_i = 1'b1;
    hold(1'b1, 4 * BIT_CLKS + 20);
    send_frame(8'h81, 1'b1);
    hold(1'b1, 8);
    checks++;
    if (rcv_q.size() != 1 || rcv_q[0] !== 8'h81) begin
      errors++; $display("[TB] FAIL rst_mid_data: got %0d bytes (first %h), required 1 byte 81",
                         rcv_q.size(), (rcv_q.size() > 0) ? rcv_q[0] : 8'hxx);
    end
    checks++;
    if (frame_err_cnt != 0) begin
      errors++; $display("[TB] FAIL rst_mid_ferr: got %0d, required 0", frame_err_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [3];
    bytes[0] = 8'h00;
    bytes[1] = 8'hFF;
    bytes[2] = 8'h5A;
    clear_stats();
    ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(bytes[i]);
      send_frame(bytes[i], 1'b1);
    end
    hold(1'b1, 8);
    checks++;
    if (rcv_q.size() != exp_q.size()) begin
      errors++; $display("[TB] FAIL b2b_len: got %0d, required %0d", rcv_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (rcv_q[i] !== exp_q[i]) begin
          errors++; $display("[TB] FAIL b2b[%0d]: got %h, required %h", i, rcv_q[i], exp_q[i]);
        end
      end
    end
    checks++;
    if (frame_err_cnt != 0 || overrun_cnt != 0) begin
      errors++; $display("[TB] FAIL b2b_errs: got fe=%0d ov=%0d, required 0 0", frame_err_cnt, overrun_cnt);
    end
  endtask

  task automatic test_random();
    int         exp_fe;
    logic [7:0] b;
    bit         bad;
    clear_stats();
    exp_fe     = 0;
    rand_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      b   = 8'($urandom);
      bad = ($urandom_range(0, 5) == 0);
      send_frame(b, !bad);
      if (bad) begin
        exp_fe++;
        hold(1'b0, $urandom_range(0, 30));
        hold(1'b1, 20 + $urandom_range(0, 10));
      end else begin
        exp_q.push_back(b);
        hold(1'b1, $urandom_range(0, 10));
      end
    end
    hold(1'b1, 10);
    rand_ready = 1'b0;
    @(posedge clk_clk);
    #2;
    ready_i = 1'b1;
    hold(1'b1, 30);
    checks++;
    if (rcv_q.size() != exp_q.size()) begin
      errors++; $display("[TB] FAIL rand_len: got %0d, required %0d", rcv_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (rcv_q[i] !== exp_q[i]) begin
          errors++; $display("[TB] FAIL rand[%0d]: got %h, required %h", i, rcv_q[i], exp_q[i]);
        end
      end
    end
    checks++;
    if (frame_err_cnt != exp_fe) begin
      errors++; $display("[TB] FAIL rand_ferr: got %0d, required %0d", frame_err_cnt, exp_fe);
    end
    checks++;
    if (overrun_cnt != 0) begin
      errors++; $display("[TB] FAIL rand_overrun: got %0d, required 0", overrun_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_glitch();
    test_frame_error();
    test_overrun();
    test_reset_mid_frame();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
